// File: rtl/counter_updown_mod.sv
// Configurable-width up/down modulo counter: wrap or saturate at 0/MAX_VALUE, clear, clamped load,
// registered terminal pulse, sticky boundary flag. Define COUNTER_PRESCALE_EN to divide enable by PRESCALE_DIV.
module counter_updown_mod #(
    parameter int     WIDTH        = 8,
    parameter longint MAX_VALUE    = 255,
    parameter longint RESET_VALUE  = 0,
    parameter int     PRESCALE_DIV = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    input  logic             up_down,
    input  logic             saturate,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] counter_out,
    output logic             terminal,
    output logic             boundary_hit,
    output logic             at_zero
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VALUE);
    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VALUE);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("counter_updown_mod: WIDTH must be 2..32");
        end
        if (MAX_VALUE < 64'sd1 || MAX_VALUE > ((64'sd1 <<< WIDTH) - 64'sd1)) begin : g_bad_max
            $error("counter_updown_mod: MAX_VALUE must be 1..2**WIDTH-1");
        end
        if (RESET_VALUE < 64'sd0 || RESET_VALUE > MAX_VALUE) begin : g_bad_reset
            $error("counter_updown_mod: RESET_VALUE must be 0..MAX_VALUE");
        end
        if (PRESCALE_DIV < 2 || PRESCALE_DIV > 256) begin : g_bad_prescale
            $error("counter_updown_mod: PRESCALE_DIV must be 2..256");
        end
    endgenerate

    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] value);
        return (value > MAX_V) ? MAX_V : value;
    endfunction

    // Next count for one step; MAX_V rather than 2**WIDTH-1 is the wrap point.
    function automatic logic [WIDTH-1:0] step_value(input logic [WIDTH-1:0] cnt,
                                                    input logic             up,
                                                    input logic             sat);
        logic [WIDTH-1:0] nxt;
        if (up) begin
            if (cnt >= MAX_V) nxt = sat ? MAX_V : '0;
            else              nxt = cnt + WIDTH'(1);
        end else begin
            if (cnt == '0)    nxt = sat ? '0 : MAX_V;
            else              nxt = cnt - WIDTH'(1);
        end
        return nxt;
    endfunction

    logic step;
    logic at_max;
    logic boundary_step;

`ifdef COUNTER_PRESCALE_EN
    localparam int               PRE_W    = $clog2(PRESCALE_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE_DIV - 1);

    logic [PRE_W-1:0] prescale;

    assign step = enable && (prescale == PRE_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prescale <= '0;
        end else if (clear || load) begin
            prescale <= '0;
        end else if (enable) begin
            prescale <= (prescale == PRE_LAST) ? '0 : prescale + PRE_W'(1);
        end
    end
`else
    assign step = enable;
`endif

    assign at_zero       = (counter_out == '0);
    assign at_max        = (counter_out == MAX_V);
    assign boundary_step = step && (up_down ? at_max : at_zero);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            counter_out  <= RST_V;
            terminal     <= 1'b0;
            boundary_hit <= 1'b0;
        end else if (clear) begin
            counter_out  <= RST_V;
            terminal     <= 1'b0;
            boundary_hit <= 1'b0;
        end else if (load) begin
            counter_out  <= clamp_load(load_value);
            terminal     <= 1'b0;
        end else if (step) begin
            counter_out  <= step_value(counter_out, up_down, saturate);
            terminal     <= boundary_step;
            if (boundary_step) boundary_hit <= 1'b1;
        end else begin
            terminal     <= 1'b0;
        end
    end

endmodule
